ddr_packet_reader_256: RTL and testbench
========================================

Name: ddr_packet_reader_256

Overview:
Downstream stage of the DDR setup writer. Once the 256-bit DDR packet image is loaded (setup_done), it reads the image back line by line through the same word-addressed request interface the setup stage feeds (rd_rq/rd_adr/rd_valid/rd_data). It serialises the image into a 32-bit valid/ready packet stream with sop/eop/empty for the SFP TX path. The packet is replayed continuously with a programmable inter-packet gap.

Parameters:
BASE_ADDR, 25'd1, DDR line address of the header line.
MAX_LEN, 1518, largest legal packet length in bytes.
GAP_CYCLES, 12, idle cycles between end of one packet and the next header read.
TIMEOUT, 1023, max cycles to wait for rd_valid after rd_rq is raised.

Ports:
clk  in  1  clk_125_tx_rx domain clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level; tied to setup_done; reader runs only while high.
enable  in  1  level; when low, stops after the current packet completes.
rd_rq  out  1  read request; held until rd_valid.
rd_adr  out  25  DDR line address.
rd_valid  in  1  one-cycle pulse qualifying rd_data.
rd_data  in  256  read line; word k is in bits [32k+31:32k].
tx_data  out  32  stream word.
tx_valid  out  1  tx_data is valid.
tx_ready  in  1  consumer accepts when tx_valid & tx_ready.
tx_sop  out  1  first word of packet.
tx_eop  out  1  last word of packet.
tx_empty  out  2  unused bytes in the eop word (upper bytes); 0 when not eop.
busy  out  1  high in any state except IDLE.
pkt_count  out  16  packets fully sent; wraps at 0xFFFF -> 0.
err_len  out  1  sticky; illegal header length seen.
err_timeout  out  1  sticky; read timed out.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Header line at BASE_ADDR: bits [31:0] are len in bytes. Payload starts at BASE_ADDR+1, 8 words per line, word 0 first on the wire.
- nwords = (len+3)>>2. Last-word empty = (4 - len[1:0]) & 3.
- FSM states:
  - IDLE: go to RD_HDR when start & enable.
  - RD_HDR: rd_rq=1, rd_adr=BASE_ADDR. On rd_valid, latch len.
    - If len==0 or len>MAX_LEN: set err_len, go to GAP.
    - Otherwise go to RD_LINE with line address BASE_ADDR+1 and word count 0.
  - RD_LINE: rd_rq=1, rd_adr = current line. On rd_valid, capture rd_data into the line register, set word index 0, go to SEND.
  - SEND: tx_valid=1, tx_data = line register word[idx].
    - tx_sop=1 when the global word count is 0.
    - tx_eop=1 when the global word count is nwords-1.
    - On handshake: advance idx and word count.
    - After eop: pkt_count++, go to GAP.
    - Else if idx was 7: line address+1, go to RD_LINE.
    - Output words must hold stable while tx_valid & !tx_ready.
  - GAP: count GAP_CYCLES cycles. Then go to RD_HDR if start & enable, else IDLE.
- Read timing: rd_rq rises on the cycle a read state is entered and drops the cycle after rd_valid. One read is outstanding at most. rd_valid outside a read state is ignored.
- Timeout: a cycle counter runs in the read states. When it reaches TIMEOUT without rd_valid: set err_timeout, drop rd_rq, go to IDLE. No eop is emitted; the downstream consumer discards the partial packet.
- start deasserting mid-packet: finish the packet, then go to IDLE. enable behaves the same way. A packet is never truncated except on timeout.
- Error flags clear only on reset.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no handshake completes.
- Line address arithmetic is 25-bit and wraps modulo 2^25.

Decomposition:
- Shared package ddr_pkt_pkg:
  - state enum (IDLE, RD_HDR, RD_LINE, SEND, GAP)
  - DDR_LINE_W=256, WORD_W=32, WORDS_PER_LINE=8, ADDR_W=25
  - function calc_nwords(len)
  - function calc_empty(len)
- Sub-module line_serializer_256: line register, word index, valid/ready output. Kept as the single sub-module; FSM and read control stay in the top.

Test Plan:
- Header len=0x40 at addr 1; lines at 2,3 hold 0..15 -> exactly 2 line reads (rd_adr 2,3). 16 words 0..15 out; sop on word 0, eop on word 15, tx_empty=0; pkt_count=1.
- len=46 (0x2E) -> 12 words over 2 lines. eop on word 11 with tx_empty=2. Next header read occurs exactly GAP_CYCLES cycles after the eop handshake.
- Random tx_ready (50%) on the len=64 packet -> tx_data/sop/eop stable while stalled; same 16-word sequence; no extra rd_rq.
- len=0, then len=2000 -> err_len=1, no tx_valid, FSM cycles through GAP. Then with len=64 restored, the next packet streams normally and err_len stays 1.
- Withhold rd_valid on a payload line -> rd_rq drops after TIMEOUT cycles; err_timeout=1; state IDLE; no eop.
- Assert rst_n=0 mid-SEND (word 5) -> all outputs 0 in the same cycle. After release with start=1, the packet restarts from the header read with sop.

Source files
------------

// File: rtl/ddr_packet_reader_256_pkg.sv
// ddr_pkt_pkg: shared types, widths and length helpers for the DDR packet reader
package ddr_pkt_pkg;
  localparam int DDR_LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int ADDR_W = 25;
  typedef enum logic [2:0] {IDLE, RD_HDR, RD_LINE, SEND, GAP} state_t;
  function automatic logic [15:0] calc_nwords(input logic [31:0] len);
    logic [31:0] n;
    n = (len + 32'd3) >> 2;
    return n[15:0];
  endfunction
  function automatic logic [1:0] calc_empty(input logic [31:0] len);
    return 2'd0 - len[1:0];
  endfunction
endpackage

// File: rtl/ddr_packet_reader_256_line_serializer.sv
// line_serializer_256: holds one DDR line and presents it word by word on a valid/ready port
module line_serializer_256
  import ddr_pkt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DDR_LINE_W-1:0] line_in,
  input  logic                  active,
  input  logic                  tx_ready,
  output logic [WORD_W-1:0]     tx_data,
  output logic                  tx_valid,
  output logic                  last
);
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_q;
  logic [$clog2(WORDS_PER_LINE)-1:0]     idx;
  assign tx_valid = active;
  assign tx_data = active ? line_q[idx] : '0;
  assign last = idx == 3'(WORDS_PER_LINE - 1);
  // capture a fresh line and restart at word 0, otherwise step on each accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      idx <= '0;
    end else if (load) begin
      line_q <= line_in;
      idx <= '0;
    end else if (tx_valid && tx_ready) begin
      idx <= idx + 1'b1;
    end
  end
endmodule

// File: rtl/ddr_packet_reader_256.sv
// ddr_packet_reader_256: replays a DDR-resident packet image as a 32-bit sop/eop stream
module ddr_packet_reader_256
  import ddr_pkt_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 25'd1,
  parameter int MAX_LEN = 1518,
  parameter int GAP_CYCLES = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  enable,
  output logic                  rd_rq,
  output logic [ADDR_W-1:0]     rd_adr,
  input  logic                  rd_valid,
  input  logic [DDR_LINE_W-1:0] rd_data,
  output logic [WORD_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [1:0]            tx_empty,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic                  err_len,
  output logic                  err_timeout
);
  state_t              state, state_n;
  logic [ADDR_W-1:0]   line_addr;
  logic [15:0]         nwords, wcnt, tcnt, gcnt;
  logic [1:0]          empty_q;
  logic [31:0]         hdr_len;
  logic                rd_state, fire, is_eop, timeout, len_bad, go, idx_last;
  assign go = start && enable;
  assign rd_state = state == RD_HDR || state == RD_LINE;
  assign hdr_len = rd_data[31:0];
  assign len_bad = hdr_len == 32'd0 || hdr_len > 32'(MAX_LEN);
  assign fire = tx_valid && tx_ready;
  assign is_eop = state == SEND && wcnt == nwords - 16'd1;
  assign timeout = rd_state && !rd_valid && tcnt == 16'(TIMEOUT - 1);
  assign rd_rq = rd_state;
  assign rd_adr = state == RD_HDR ? BASE_ADDR : state == RD_LINE ? line_addr : '0;
  assign busy = state != IDLE;
  assign tx_sop = tx_valid && wcnt == 16'd0;
  assign tx_eop = tx_valid && is_eop;
  assign tx_empty = tx_eop ? empty_q : 2'd0;
  line_serializer_256 u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == RD_LINE && rd_valid),
    .line_in  (rd_data),
    .active   (state == SEND),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .last     (idx_last)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next-state: reads, streaming, inter-packet gap, timeout abort
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? RD_HDR : IDLE;
      RD_HDR:  state_n = rd_valid ? (len_bad ? GAP : RD_LINE) : timeout ? IDLE : RD_HDR;
      RD_LINE: state_n = rd_valid ? SEND : timeout ? IDLE : RD_LINE;
      SEND:    state_n = !fire ? SEND : is_eop ? GAP : idx_last ? RD_LINE : SEND;
      GAP:     state_n = gcnt == 16'(GAP_CYCLES - 1) ? (go ? RD_HDR : IDLE) : GAP;
      default: state_n = IDLE;
    endcase
  end
  // header latch, word/line bookkeeping, wait counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr <= '0;
      nwords <= '0;
      wcnt <= '0;
      tcnt <= '0;
      gcnt <= '0;
      empty_q <= '0;
      pkt_count <= '0;
      err_len <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tcnt <= rd_state && !rd_valid && !timeout ? tcnt + 16'd1 : 16'd0;
      gcnt <= state == GAP ? gcnt + 16'd1 : 16'd0;
      if (timeout) err_timeout <= 1'b1;
      if (state == RD_HDR && rd_valid) begin
        nwords <= calc_nwords(hdr_len);
        empty_q <= calc_empty(hdr_len);
        wcnt <= '0;
        line_addr <= BASE_ADDR + 25'd1;
        err_len <= err_len | len_bad;
      end
      if (state == SEND && fire) begin
        wcnt <= wcnt + 16'd1;
        if (is_eop) pkt_count <= pkt_count + 16'd1;
        else if (idx_last) line_addr <= line_addr + 25'd1;
      end
    end
  end
endmodule

// File: tb/tb_ddr_packet_reader_256.sv
// tb_ddr_packet_reader_256: scoreboard bench with a DDR line responder and a stream monitor
module tb_ddr_packet_reader_256;
  logic         clk, rst_n, start, enable, rd_rq, rd_valid, tx_valid, tx_ready;
  logic         tx_sop, tx_eop, busy, err_len, err_timeout;
  logic [24:0]  rd_adr;
  logic [255:0] rd_data;
  logic [31:0]  tx_data;
  logic [1:0]   tx_empty;
  logic [15:0]  pkt_count;
  typedef struct {logic [31:0] d; logic s; logic e; logic [1:0] m;} exp_t;
  exp_t         exp_q[$];
  logic [24:0]  adr_log[$];
  logic [255:0] mem[16];
  logic [24:0]  hold_adr;
  int checks, errors, cyc, last_eop, gap_meas, hdr_reads, hold_len, valid_cycles, ready_mode;
  ddr_packet_reader_256 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
    .rd_rq(rd_rq), .rd_adr(rd_adr), .rd_valid(rd_valid), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty),
    .busy(busy), .pkt_count(pkt_count), .err_len(err_len), .err_timeout(err_timeout)
  );
  initial begin
    clk = 0;
    forever #4 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic push_words(input int n, input logic [1:0] emp, input bit has_eop);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.d = k;
      e.s = k == 0;
      e.e = has_eop && k == n - 1;
      e.m = e.e ? emp : 2'd0;
      exp_q.push_back(e);
    end
  endtask
  task automatic wait_pkts(input int n);
    for (int i = 0; i < 4000 && pkt_count != 16'(n); i++) @(negedge clk);
    check("pkt_count_reached", pkt_count, n);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
    check("returned_idle", busy, 0);
  endtask
  task automatic wait_hdr(input int n);
    for (int i = 0; i < 4000 && hdr_reads != n; i++) @(negedge clk);
    check("hdr_read_seen", hdr_reads, n);
    repeat (6) @(negedge clk);
  endtask
  // tx_ready driver: always-ready or 50% random
  initial begin
    tx_ready = 1;
    forever begin
      @(posedge clk);
      #1 tx_ready = ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  // DDR responder: answers each read two cycles after it starts unless the line is withheld
  initial begin
    logic prev_rq, prev_v;
    int lat;
    rd_valid = 0; rd_data = '0; prev_rq = 0; prev_v = 0; lat = 0;
    forever begin
      @(posedge clk);
      #1 rd_valid = 0;
      if (rd_rq) begin
        if (!prev_rq || prev_v) begin
          lat = 0;
          if (rd_adr == 25'd1) begin
            hdr_reads++;
            gap_meas = cyc - last_eop;
          end
        end else lat++;
        if (rd_adr == hold_adr) hold_len++;
        else if (lat == 2) begin
          rd_valid = 1;
          rd_data = mem[rd_adr[3:0]];
          adr_log.push_back(rd_adr);
        end
      end
      prev_rq = rd_rq;
      prev_v = rd_valid;
    end
  end
  // monitor: pops the scoreboard on every accepted word and checks stall stability
  initial begin
    logic stall_prev, ps, pe;
    logic [31:0] pd;
    stall_prev = 0; ps = 0; pe = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (tx_valid) valid_cycles++;
      if (stall_prev && rst_n) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, pd);
        check("stall_sop", tx_sop, ps);
        check("stall_eop", tx_eop, pe);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %0h want none", tx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", tx_data, e.d);
          check("word_sop", tx_sop, e.s);
          check("word_eop", tx_eop, e.e);
          check("word_empty", tx_empty, e.m);
        end
        if (tx_eop) last_eop = cyc + 1;
      end
      stall_prev = tx_valid && !tx_ready;
      pd = tx_data; ps = tx_sop; pe = tx_eop;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n0, vc0;
    rst_n = 0; start = 0; enable = 0; ready_mode = 0; hold_adr = 25'h1FFFFFF;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int k = 0; k < 16; k++) mem[2 + k / 8][32 * (k % 8) +: 32] = k;
    mem[1][31:0] = 32'd64;
    #1;
    check("rst_rd_rq", rd_rq, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_errs", {err_len, err_timeout}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    // len=64: two payload lines, 16 words
    push_words(16, 2'd0, 1);
    start = 1; enable = 1;
    wait_pkts(1);
    enable = 0;
    wait_idle();
    check("t1_reads", adr_log.size(), 3);
    check("t1_adr0", adr_log[0], 1);
    check("t1_adr1", adr_log[1], 2);
    check("t1_adr2", adr_log[2], 3);
    check("t1_queue_drained", exp_q.size(), 0);
    // len=46: 12 words, empty=2, two back-to-back packets to measure the gap
    mem[1][31:0] = 32'd46;
    push_words(12, 2'd2, 1);
    push_words(12, 2'd2, 1);
    enable = 1;
    wait_pkts(3);
    enable = 0;
    wait_idle();
    check("t2_gap", gap_meas, 12);
    check("t2_queue_drained", exp_q.size(), 0);
    // len=64 under random backpressure
    mem[1][31:0] = 32'd64;
    n0 = adr_log.size();
    ready_mode = 1;
    push_words(16, 2'd0, 1);
    enable = 1;
    wait_pkts(4);
    enable = 0;
    wait_idle();
    ready_mode = 0;
    check("t3_reads", adr_log.size(), n0 + 3);
    check("t3_queue_drained", exp_q.size(), 0);
    // illegal lengths 0 and 2000, then recovery
    mem[1][31:0] = 32'd0;
    vc0 = valid_cycles;
    n0 = hdr_reads;
    enable = 1;
    wait_hdr(n0 + 1);
    check("t4_err_len_zero", err_len, 1);
    mem[1][31:0] = 32'd2000;
    wait_hdr(n0 + 2);
    check("t4_no_pkt", pkt_count, 4);
    check("t4_in_gap", busy, 1);
    check("t4_no_valid", valid_cycles, vc0);
    mem[1][31:0] = 32'd64;
    push_words(16, 2'd0, 1);
    wait_pkts(5);
    enable = 0;
    wait_idle();
    check("t4_err_len_sticky", err_len, 1);
    check("t4_queue_drained", exp_q.size(), 0);
    // withhold the second payload line
    hold_adr = 25'd3;
    hold_len = 0;
    push_words(8, 2'd0, 0);
    enable = 1;
    for (int i = 0; i < 200 && !tx_valid; i++) @(negedge clk);
    check("t5_started", tx_valid, 1);
    enable = 0;
    for (int i = 0; i < 3000 && !err_timeout; i++) @(negedge clk);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_rq_cycles", hold_len, 1023);
    check("t5_rd_rq_low", rd_rq, 0);
    check("t5_idle", busy, 0);
    check("t5_pkt_count", pkt_count, 5);
    check("t5_queue_drained", exp_q.size(), 0);
    hold_adr = 25'h1FFFFFF;
    // reset while word 5 is presented
    push_words(5, 2'd0, 0);
    enable = 1;
    for (int i = 0; i < 3000 && !(tx_valid && tx_data == 32'd5); i++) begin
      @(posedge clk);
      #2;
    end
    check("t6_word5_seen", tx_data, 5);
    rst_n = 0;
    #1;
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_tx_data", tx_data, 0);
    check("t6_rst_sop_eop", {tx_sop, tx_eop, tx_empty}, 0);
    check("t6_rst_rd", {rd_rq, rd_adr}, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cnt", pkt_count, 0);
    check("t6_rst_errs", {err_len, err_timeout}, 0);
    check("t6_queue_drained", exp_q.size(), 0);
    @(negedge clk);
    push_words(16, 2'd0, 1);
    rst_n = 1;
    wait_pkts(1);
    enable = 0;
    wait_idle();
    check("t6_queue_drained_after", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
